// File: rtl/pixel_raster_writer_if.sv
// -----------------------------------------------------------------------------
// pixel_raster_writer_if
//   Bundles the two streams of the raster writer:
//     - the incoming watermarked pixel stream (pix_valid / pix_data), which has
//       no ready signal: the producer never waits;
//     - the outgoing ready/valid write requests to the output image memory
//       (out_valid / out_ready / out_addr / out_data).
//
//   Modports:
//     master : the environment side (pixel producer and memory), drives the
//              pixel stream and out_ready, observes the write requests.
//     slave  : the raster writer itself.
// -----------------------------------------------------------------------------
interface pixel_raster_writer_if #(
    parameter int Data_Depth = 8,
    parameter int Addr_Width = 21
);
    logic                  pix_valid;
    logic [Data_Depth-1:0] pix_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [Addr_Width-1:0] out_addr;
    logic [Data_Depth-1:0] out_data;

    modport master (
        output pix_valid,
        output pix_data,
        output out_ready,
        input  out_valid,
        input  out_addr,
        input  out_data
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  out_ready,
        output out_valid,
        output out_addr,
        output out_data
    );
endinterface

// File: rtl/pixel_raster_writer.sv
// -----------------------------------------------------------------------------
// pixel_raster_writer
//   Downstream stage of the watermarking top level. Pixels arrive block by
//   block (blocks row-major, pixels row-major inside a block). Each pixel is
//   given its raster-order address in the output image and queued in a small
//   FIFO that issues ready/valid write requests to the output memory.
//
//   Ports:
//     clk, rst          clock, asynchronous active-low reset
//     cfg_load          latch cfg_Np / cfg_M / cfg_base (only while idle)
//     cfg_Np            image side in pixels
//     cfg_M             block side in pixels
//     cfg_base          output address of raster pixel (0,0)
//     bus (slave)       pixel stream in, write requests out
//     busy              a frame is in progress
//     frame_done        one-cycle pulse once the last write has been accepted
//     cfg_err           sticky: last cfg_load was rejected
//     ovf_err           sticky: a pixel was dropped on a full FIFO
// -----------------------------------------------------------------------------
module pixel_raster_writer #(
    parameter int Data_Depth  = 8,
    parameter int Addr_Width  = 21,
    parameter int Dim_Width   = 10,
    parameter int Block_Depth = 7,
    parameter int Fifo_Depth  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_load,
    input  logic [Dim_Width-1:0]   cfg_Np,
    input  logic [Block_Depth-1:0] cfg_M,
    input  logic [Addr_Width-1:0]  cfg_base,
    pixel_raster_writer_if.slave   bus,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   cfg_err,
    output logic                   ovf_err
);

    localparam int PtrW = (Fifo_Depth > 1) ? $clog2(Fifo_Depth) : 1;
    localparam int CntW = 2 * Dim_Width;

    typedef logic [PtrW-1:0]        ptr_t;
    typedef logic [PtrW:0]          lvl_t;
    typedef logic [CntW-1:0]        cnt_t;
    typedef logic [Dim_Width-1:0]   dim_t;
    typedef logic [Block_Depth-1:0] blk_t;
    typedef logic [Addr_Width-1:0]  addr_t;

    localparam ptr_t PTR_ONE  = ptr_t'(1);
    localparam lvl_t LVL_ONE  = lvl_t'(1);
    localparam lvl_t LVL_FULL = lvl_t'(Fifo_Depth);
    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam dim_t DIM_ONE  = dim_t'(1);
    localparam blk_t BLK_ONE  = blk_t'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        addr_t                 addr;
        logic [Data_Depth-1:0] data;
    } entry_t;

    // ---------------------------------------------------------------- state
    state_t state;

    dim_t   np_r;
    blk_t   m_r;
    cnt_t   total_r;     // Np*Np, computed once per frame at configuration
    cnt_t   pix_cnt;

    // Position inside the current block, and the column offset of the block
    // (bcol*M). row_base is the raster address of (row, col=0) of the block's
    // leftmost column; blk_base is the address of the top-left pixel of the
    // current block row. Together they let every address be formed with
    // adders only.
    blk_t   col;
    blk_t   row;
    dim_t   bcol_off;
    addr_t  row_base;
    addr_t  blk_base;

    entry_t mem [Fifo_Depth];
    ptr_t   wr_ptr;
    ptr_t   rd_ptr;
    lvl_t   level;

    // ----------------------------------------------------- configuration check
    dim_t cfg_m_ext;
    dim_t cfg_m_div;
    logic cfg_bad;

    assign cfg_m_ext = dim_t'(cfg_M);
    // Keep the modulo operand non-zero; M=0 is rejected by its own term.
    assign cfg_m_div = (cfg_M == '0) ? DIM_ONE : cfg_m_ext;
    assign cfg_bad   = (cfg_M == '0) || (cfg_Np == '0) ||
                       (cfg_m_ext > cfg_Np) || ((cfg_Np % cfg_m_div) != '0);

    // ------------------------------------------------------ address datapath
    addr_t cur_addr;
    addr_t np_addr;
    dim_t  bcol_next;
    logic  col_last;
    logic  row_last;
    logic  bcol_last;
    logic  frame_last;

    assign cur_addr   = row_base + addr_t'(bcol_off) + addr_t'(col);
    assign np_addr    = addr_t'(np_r);
    assign bcol_next  = bcol_off + dim_t'(m_r);
    assign col_last   = (col == m_r - BLK_ONE);
    assign row_last   = (row == m_r - BLK_ONE);
    assign bcol_last  = (bcol_next == np_r);
    assign frame_last = (pix_cnt + CNT_ONE == total_r);

    // ------------------------------------------------------------ FIFO flags
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push_req;
    logic push_ok;

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LVL_FULL);
    assign pop        = !fifo_empty && bus.out_ready;
    assign push_req   = (state == RUN) && bus.pix_valid;
    // A full FIFO still takes a pixel when its head leaves in the same cycle.
    assign push_ok    = push_req && (!fifo_full || pop);

    // The head entry drives the request directly, so it stays stable for as
    // long as the memory stalls.
    entry_t head;
    assign head          = mem[rd_ptr];
    assign bus.out_valid = !fifo_empty;
    assign bus.out_addr  = head.addr;
    assign bus.out_data  = head.data;

    // ------------------------------------------------------------------ FIFO
    // NOTE: storage is only a few entries, so it is reset along with the
    // pointers; this keeps out_addr/out_data at 0 after reset instead of X.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Fifo_Depth; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= '{addr: cur_addr, data: bus.pix_data};
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_ok && !pop) begin
                level <= level + LVL_ONE;
            end else if (pop && !push_ok) begin
                level <= level - LVL_ONE;
            end
        end
    end

    // ------------------------------------------------- control and counters
    // NOTE: every register here is state, so all assignments are
    // non-blocking; a blocking assignment would let later statements in the
    // block see the new value within the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            ovf_err    <= 1'b0;
            np_r       <= '0;
            m_r        <= '0;
            total_r    <= '0;
            pix_cnt    <= '0;
            col        <= '0;
            row        <= '0;
            bcol_off   <= '0;
            row_base   <= '0;
            blk_base   <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_load) begin
                        if (cfg_bad) begin
                            cfg_err <= 1'b1;
                        end else begin
                            cfg_err  <= 1'b0;
                            ovf_err  <= 1'b0;
                            np_r     <= cfg_Np;
                            m_r      <= cfg_M;
                            total_r  <= cnt_t'(cfg_Np) * cnt_t'(cfg_Np);
                            pix_cnt  <= '0;
                            col      <= '0;
                            row      <= '0;
                            bcol_off <= '0;
                            row_base <= cfg_base;
                            blk_base <= cfg_base;
                            busy     <= 1'b1;
                            state    <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (bus.pix_valid) begin
                        // Dropped pixels still advance the counters so the
                        // pixels after them land on their proper addresses.
                        if (!push_ok) begin
                            ovf_err <= 1'b1;
                        end
                        pix_cnt <= pix_cnt + CNT_ONE;
                        if (col_last) begin
                            col <= '0;
                            if (row_last) begin
                                row <= '0;
                                if (bcol_last) begin
                                    // Next block row starts one image row
                                    // below the last row of this block row.
                                    bcol_off <= '0;
                                    row_base <= row_base + np_addr;
                                    blk_base <= row_base + np_addr;
                                end else begin
                                    bcol_off <= bcol_next;
                                    row_base <= blk_base;
                                end
                            end else begin
                                row      <= row + BLK_ONE;
                                row_base <= row_base + np_addr;
                            end
                        end else begin
                            col <= col + BLK_ONE;
                        end
                        if (frame_last) begin
                            state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    if (fifo_empty) begin
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_raster_writer.sv
// -----------------------------------------------------------------------------
// tb_pixel_raster_writer
//   Drives pixel_raster_writer with directed and randomized frames. The
//   reference model keeps the expected write requests in a queue; the address
//   of pixel i is derived directly from its block / in-block position with
//   division and modulo.
// -----------------------------------------------------------------------------
module tb_pixel_raster_writer;

    localparam int DD = 8;
    localparam int AW = 21;
    localparam int DW = 10;
    localparam int BD = 7;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_load = 1'b0;
    logic [DW-1:0] cfg_Np = '0;
    logic [BD-1:0] cfg_M = '0;
    logic [AW-1:0] cfg_base = '0;
    logic          busy;
    logic          frame_done;
    logic          cfg_err;
    logic          ovf_err;

    pixel_raster_writer_if #(.Data_Depth(DD), .Addr_Width(AW)) bus_if ();

    pixel_raster_writer #(
        .Data_Depth (DD),
        .Addr_Width (AW),
        .Dim_Width  (DW),
        .Block_Depth(BD),
        .Fifo_Depth (FD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_load  (cfg_load),
        .cfg_Np    (cfg_Np),
        .cfg_M     (cfg_M),
        .cfg_base  (cfg_base),
        .bus       (bus_if),
        .busy      (busy),
        .frame_done(frame_done),
        .cfg_err   (cfg_err),
        .ovf_err   (ovf_err)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------ checking
    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------- reference model
    typedef struct {
        logic [AW-1:0] a;
        logic [DD-1:0] d;
    } req_t;

    req_t          q[$];
    logic [AW-1:0] popped[$];
    int            m_np, m_m, total, seen, fd_seen;
    logic [AW-1:0] m_base;
    bit            running, draining, done_ph, busy_e, fd_e, cfg_err_e, ovf_e;

    function automatic logic [AW-1:0] addr_of(input int i);
        int per_blk, blk, w, bpr;
        per_blk = m_m * m_m;
        blk     = i / per_blk;
        w       = i % per_blk;
        bpr     = m_np / m_m;
        return AW'(int'(m_base) + ((blk / bpr) * m_m + w / m_m) * m_np
                   + (blk % bpr) * m_m + w % m_m);
    endfunction

    task automatic model_reset();
        q.delete();
        running   = 0;
        draining  = 0;
        done_ph   = 0;
        busy_e    = 0;
        fd_e      = 0;
        cfg_err_e = 0;
        ovf_e     = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, bus_if.out_valid, 0);
        check({tag, "_out_addr"}, bus_if.out_addr, 0);
        check({tag, "_out_data"}, bus_if.out_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_cfg_err"}, cfg_err, 0);
        check({tag, "_ovf_err"}, ovf_err, 0);
    endtask

    // One clock cycle: apply inputs, compare the registered outputs with the
    // model, then advance the model across the coming edge. Called at
    // posedge+1 and returns at the next posedge+1.
    task automatic cycle(input bit pv, input logic [DD-1:0] pd, input bit rdy, input bit ld);
        bit   pop, accepted, idle_pre, running_pre;
        int   np, mm;
        req_t r;
        bus_if.pix_valid = pv;
        bus_if.pix_data  = pd;
        bus_if.out_ready = rdy;
        cfg_load         = ld;

        check("out_valid", bus_if.out_valid, (q.size() != 0));
        if (q.size() != 0) begin
            check("out_addr", bus_if.out_addr, q[0].a);
            check("out_data", bus_if.out_data, q[0].d);
        end
        check("busy", busy, busy_e);
        check("frame_done", frame_done, fd_e);
        check("cfg_err", cfg_err, cfg_err_e);
        check("ovf_err", ovf_err, ovf_e);
        if (bus_if.out_valid === 1'b1 && rdy) popped.push_back(bus_if.out_addr);
        if (frame_done === 1'b1) fd_seen++;

        idle_pre    = !busy_e;
        running_pre = running;
        pop         = (q.size() != 0) && rdy;
        accepted    = 0;
        fd_e        = 0;

        if (done_ph) begin
            done_ph = 0;
            busy_e  = 0;
        end else if (draining && q.size() == 0) begin
            draining = 0;
            done_ph  = 1;
            fd_e     = 1;
        end

        if (idle_pre && ld) begin
            np = int'(cfg_Np);
            mm = int'(cfg_M);
            if (mm == 0 || np == 0 || mm > np || (np % mm) != 0) begin
                cfg_err_e = 1;
            end else begin
                cfg_err_e = 0;
                ovf_e     = 0;
                m_np      = np;
                m_m       = mm;
                m_base    = cfg_base;
                total     = np * np;
                seen      = 0;
                running   = 1;
                busy_e    = 1;
            end
        end

        if (running_pre && pv) begin
            r.a      = addr_of(seen);
            r.d      = pd;
            accepted = (q.size() < FD) || pop;
            if (!accepted) ovf_e = 1;
            seen++;
            if (seen == total) begin
                running  = 0;
                draining = 1;
            end
        end

        if (pop) void'(q.pop_front());
        if (accepted) q.push_back(r);

        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check_all_zero("mid_rst");
        model_reset();
        bus_if.pix_valid = 1'b0;
        cfg_load         = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // mode 0: one pixel per cycle, ready high
    // mode 1: as 0 but memory stalls on stream cycles 3..5
    // mode 2: memory stalled for the whole stream
    // mode 3: random pixel gaps, random ready, stray cfg_load pulses
    task automatic run_frame(input int np, input int m, input logic [AW-1:0] base,
                             input int mode, input int abort_at);
        int k, guard, fd0;
        bit pv, rdy, ld;
        logic [DD-1:0] pd;
        cfg_Np   = DW'(np);
        cfg_M    = BD'(m);
        cfg_base = base;
        popped.delete();
        fd0 = fd_seen;
        cycle(1'b0, '0, 1'b1, 1'b1);
        k     = 0;
        guard = 0;
        while (running && guard < 30000) begin
            if (abort_at >= 0 && k == abort_at) begin
                do_reset();
                return;
            end
            pv = (mode == 3) ? ($urandom_range(0, 3) != 0) : 1'b1;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = !(k >= 3 && k <= 5);
                2:       rdy = 1'b0;
                default: rdy = ($urandom_range(0, 2) != 0);
            endcase
            ld = (mode == 3) && ($urandom_range(0, 15) == 0);
            pd = (mode == 3) ? DD'($urandom) : DD'(k);
            cycle(pv, pd, rdy, ld);
            if (pv) k++;
            guard++;
        end
        while (busy_e && guard < 30000) begin
            rdy = (mode == 3) ? ($urandom_range(0, 1) != 0) : 1'b1;
            cycle($urandom_range(0, 1) != 0, DD'($urandom), rdy, 1'b0);
            guard++;
        end
        check("end_busy", busy, 0);
        check("frame_done_count", fd_seen, fd0 + 1);
    endtask

    task automatic check_s1_list(input string tag, input int n);
        logic [AW-1:0] exp_list [16];
        exp_list = '{21'h100, 21'h101, 21'h104, 21'h105, 21'h102, 21'h103, 21'h106, 21'h107,
                     21'h108, 21'h109, 21'h10C, 21'h10D, 21'h10A, 21'h10B, 21'h10E, 21'h10F};
        check({tag, "_len"}, popped.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < popped.size()) check({tag, "_addr"}, popped[i], exp_list[i]);
        end
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        int np_tab [8];
        int m_tab  [8];
        int bad_np [4];
        int bad_m  [4];
        np_tab = '{6, 8, 9, 12, 5, 16, 20, 8};
        m_tab  = '{3, 4, 3, 1, 5, 8, 4, 2};
        bad_np = '{10, 4, 5, 0};
        bad_m  = '{3, 8, 0, 2};

        bus_if.pix_valid = 1'b0;
        bus_if.pix_data  = '0;
        bus_if.out_ready = 1'b0;
        fd_seen          = 0;
        model_reset();

        #2;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Directed frame, free-flowing memory.
        run_frame(4, 2, 21'h100, 0, -1);
        check_s1_list("s1", 16);

        // Short stall that the FIFO absorbs.
        run_frame(4, 2, 21'h100, 1, -1);
        check_s1_list("s2", 16);
        check("s2_ovf", ovf_err, 0);

        // Memory blocked for the whole stream: only the first FD pixels survive.
        run_frame(4, 2, 21'h100, 2, -1);
        check_s1_list("s3", 4);
        check("s3_ovf", ovf_err, 1);

        // Rejected configurations, then an accepted one.
        for (int i = 0; i < 4; i++) begin
            cfg_Np = DW'(bad_np[i]);
            cfg_M  = BD'(bad_m[i]);
            cycle(1'b1, '0, 1'b1, 1'b1);
            check("bad_cfg_err", cfg_err, 1);
            check("bad_cfg_busy", busy, 0);
        end
        run_frame(10, 5, AW'($urandom), 3, -1);
        check("good_cfg_err", cfg_err, 0);

        // Reset in the middle of a frame, then the directed frame again.
        fd_seen = 0;
        run_frame(4, 2, 21'h100, 0, 7);
        repeat (3) cycle(1'b1, '0, 1'b1, 1'b0);
        check("rst_no_frame_done", fd_seen, 0);
        run_frame(4, 2, 21'h100, 0, -1);
        check_s1_list("s5", 16);

        // Single maximal block.
        run_frame(72, 72, 21'h0, 0, -1);
        check("s6_len", popped.size(), 5184);
        for (int i = 0; i < 5184; i++) begin
            if (i < popped.size()) check("s6_addr", popped[i], i);
        end

        // Randomized frames, last one with a base that wraps the address bus.
        for (int i = 0; i < 8; i++) begin
            run_frame(np_tab[i], m_tab[i], (i == 7) ? 21'h1FFFF0 : AW'($urandom), 3, -1);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
